// File: rtl/mips_ctrl_pkg.sv
// Decode constants, ALU encoding, FSM states and the registered control word
// for the multicycle instruction controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000111;
    localparam logic [5:0] OPC_LW    = 6'b001000;
    localparam logic [5:0] OPC_SW    = 6'b001001;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_MUL = 6'b110010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MULW,
        MEM,
        WB
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_LW,
        OP_SW,
        OP_ILL
    } op_e;

    typedef struct packed {
        logic    instr_ready;
        logic    pc_write;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src_imm;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    done;
        logic    illegal;
        logic    mem_err;
        alu_op_e alu_op;
    } ctrl_out_t;

    function automatic op_e decode_op(input logic [31:0] ins);
        op_e op;
        op = OP_ILL;
        case (ins[31:26])
            OPC_LW:    op = OP_LW;
            OPC_SW:    op = OP_SW;
            OPC_RTYPE: begin
                case (ins[5:0])
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_MUL:  op = OP_MUL;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    default: op = OP_ILL;
                endcase
            end
            default:   op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic alu_op_e rtype_alu(input op_e op);
        alu_op_e a;
        case (op)
            OP_SUB:  a = ALU_SUB;
            OP_MUL:  a = ALU_MUL;
            OP_AND:  a = ALU_AND;
            OP_OR:   a = ALU_OR;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction handshake, memory acknowledge and datapath control bundle.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ack;
    logic        pc_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_imm;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        done;
    logic        illegal;
    logic        mem_err;
    logic [2:0]  alu_op;

    modport master (
        output instr, instr_valid, mem_ack,
        input  instr_ready, pc_write, reg_write, mem_read, mem_write, alu_src_imm,
               mem_to_reg, reg_dst, done, illegal, mem_err, alu_op
    );

    modport slave (
        input  instr, instr_valid, mem_ack,
        output instr_ready, pc_write, reg_write, mem_read, mem_write, alu_src_imm,
               mem_to_reg, reg_dst, done, illegal, mem_err, alu_op
    );
endinterface

// File: rtl/ctrl_cycle_counter.sv
// Purpose: loadable down-counter with zero flag, shared by MUL wait and memory timeout.
// Latency: load/decrement visible the cycle after the edge; zero is combinational on the count.
// Backpressure: none; decrement stops at zero.
module ctrl_cycle_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/multicycle_control.sv
// Purpose: multicycle FSM controller decoding R-type/LW/SW into registered datapath controls.
// Latency: done 3 cycles after accept (ALU), 2+MUL_CYCLES (MUL), 4+k (LW/SW, k extra mem waits).
// Backpressure: instr_ready only in IDLE; memory stage waits on mem_ack up to MEM_TIMEOUT cycles.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.slave bus
);
    localparam int CNT_MAX = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LOAD = CW'(MEM_TIMEOUT - 1);

    state_e      state, state_n;
    ctrl_out_t   out_q, out_n;
    logic [31:0] ir;
    logic        ir_load;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_val;
    op_e         op;
    logic        is_rtype;

    assign op       = decode_op(ir);
    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
                      (op == OP_AND) || (op == OP_OR);

    ctrl_cycle_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_q <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            out_q <= out_n;
            if (ir_load) begin
                ir <= bus.instr;
            end
        end
    end

    always_comb begin
        state_n  = state;
        out_n    = '0;
        ir_load  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        // Transitions; one-cycle pulses belong to the edge that leaves a state.
        case (state)
            IDLE: begin
                if (bus.instr_valid && out_q.instr_ready) begin
                    ir_load = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (op == OP_ILL) begin
                    state_n       = IDLE;
                    out_n.illegal = 1'b1;
                end else if (op == OP_MUL) begin
                    state_n  = MULW;
                    cnt_load = 1'b1;
                    cnt_val  = MUL_LOAD;
                end else begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (is_rtype) begin
                    state_n = WB;
                end else begin
                    state_n  = MEM;
                    cnt_load = 1'b1;
                    cnt_val  = MEM_LOAD;
                end
            end
            MULW: begin
                if (cnt_zero) state_n = WB;
                else          cnt_dec = 1'b1;
            end
            MEM: begin
                // An ack on the final allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    if (op == OP_LW) begin
                        state_n = WB;
                    end else begin
                        state_n        = IDLE;
                        out_n.done     = 1'b1;
                        out_n.pc_write = 1'b1;
                    end
                end else if (cnt_zero) begin
                    state_n       = IDLE;
                    out_n.mem_err = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Moore controls for the state being entered.
        case (state_n)
            IDLE: out_n.instr_ready = 1'b1;
            EXEC: begin
                if (is_rtype) begin
                    out_n.alu_op  = rtype_alu(op);
                    out_n.reg_dst = 1'b1;
                end else begin
                    out_n.alu_op      = ALU_ADD;
                    out_n.alu_src_imm = 1'b1;
                end
            end
            MULW: begin
                out_n.alu_op  = ALU_MUL;
                out_n.reg_dst = 1'b1;
            end
            MEM: begin
                out_n.mem_read  = (op == OP_LW);
                out_n.mem_write = (op == OP_SW);
            end
            WB: begin
                out_n.reg_write  = 1'b1;
                out_n.done       = 1'b1;
                out_n.pc_write   = 1'b1;
                out_n.mem_to_reg = (op == OP_LW);
                out_n.reg_dst    = is_rtype;
            end
            default: ;
        endcase
    end

    assign bus.instr_ready = out_q.instr_ready;
    assign bus.pc_write    = out_q.pc_write;
    assign bus.reg_write   = out_q.reg_write;
    assign bus.mem_read    = out_q.mem_read;
    assign bus.mem_write   = out_q.mem_write;
    assign bus.alu_src_imm = out_q.alu_src_imm;
    assign bus.mem_to_reg  = out_q.mem_to_reg;
    assign bus.reg_dst     = out_q.reg_dst;
    assign bus.done        = out_q.done;
    assign bus.illegal     = out_q.illegal;
    assign bus.mem_err     = out_q.mem_err;
    assign bus.alu_op      = out_q.alu_op;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, randomized transactions against a trace model,
// and an asynchronous reset abort during a multiply.
module tb_multicycle_control;
    localparam int MULC = 4;
    localparam int MEMT = 15;

    typedef struct packed {
        logic       instr_ready;
        logic       pc_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_imm;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       done;
        logic       illegal;
        logic       mem_err;
        logic [2:0] alu_op;
    } outs_t;

    typedef struct {
        string       nm;
        logic [31:0] ins;
        int          k;     // extra MEM wait cycles before ack; -1 = never
        bit          b2b;   // accepted in the cycle right after the previous one ends
        int          lat;   // expected accept-to-done cycles; -1 = no done
        bit          ill;
        bit          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    multicycle_control_if ifc ();

    multicycle_control #(.MUL_CYCLES(MULC), .MEM_TIMEOUT(MEMT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    outs_t       tq[$];
    bit          tr_mem;
    bit          pend_v = 1'b0;
    logic [31:0] pend_i = '0;
    outs_t       ZERO = '0;
    outs_t       READY;

    function automatic outs_t sample();
        outs_t s;
        s.instr_ready = ifc.instr_ready;
        s.pc_write    = ifc.pc_write;
        s.reg_write   = ifc.reg_write;
        s.mem_read    = ifc.mem_read;
        s.mem_write   = ifc.mem_write;
        s.alu_src_imm = ifc.alu_src_imm;
        s.mem_to_reg  = ifc.mem_to_reg;
        s.reg_dst     = ifc.reg_dst;
        s.done        = ifc.done;
        s.illegal     = ifc.illegal;
        s.mem_err     = ifc.mem_err;
        s.alu_op      = ifc.alu_op;
        return s;
    endfunction

    task automatic chk(input string nm, input outs_t act, input outs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected per-cycle outputs after accept, ending with the first IDLE cycle.
    task automatic build_trace(input logic [31:0] ins, input int k);
        logic [5:0] opc, fn;
        int         aluv, n;
        bit         rt, lw, sw, acked;
        outs_t      e;
        opc = ins[31:26];
        fn  = ins[5:0];
        lw  = (opc == 6'b001000);
        sw  = (opc == 6'b001001);
        rt  = 1'b0;
        aluv = 0;
        if (opc == 6'b000111) begin
            rt = 1'b1;
            case (fn)
                6'b100000: aluv = 0;
                6'b100010: aluv = 1;
                6'b110010: aluv = 2;
                6'b100100: aluv = 3;
                6'b100101: aluv = 4;
                default:   rt = 1'b0;
            endcase
        end
        tr_mem = lw || sw;
        tq.delete();
        tq.push_back(ZERO);
        if (!rt && !lw && !sw) begin
            e = READY; e.illegal = 1'b1; tq.push_back(e);
            return;
        end
        if (rt) begin
            n = (aluv == 2) ? MULC : 1;
            for (int i = 0; i < n; i++) begin
                e = ZERO; e.alu_op = 3'(aluv); e.reg_dst = 1'b1; tq.push_back(e);
            end
        end else begin
            e = ZERO; e.alu_src_imm = 1'b1; tq.push_back(e);
            acked = (k >= 0) && (k < MEMT);
            n = acked ? k + 1 : MEMT;
            for (int i = 0; i < n; i++) begin
                e = ZERO; e.mem_read = lw; e.mem_write = sw; tq.push_back(e);
            end
            if (!acked) begin
                e = READY; e.mem_err = 1'b1; tq.push_back(e);
                return;
            end
            if (sw) begin
                e = READY; e.done = 1'b1; e.pc_write = 1'b1; tq.push_back(e);
                return;
            end
        end
        e = ZERO; e.reg_write = 1'b1; e.done = 1'b1; e.pc_write = 1'b1;
        e.reg_dst = rt; e.mem_to_reg = lw;
        tq.push_back(e);
        tq.push_back(READY);
    endtask

    task automatic run_txn(input string nm, input logic [31:0] ins, input int k, input bit chained,
                           output int lat, output bit saw_ill, output bit saw_err);
        outs_t s;
        int    n;
        build_trace(ins, k);
        lat = -1; saw_ill = 1'b0; saw_err = 1'b0;
        if (!chained) begin
            @(posedge clk); #1;
            ifc.instr = ins; ifc.instr_valid = 1'b1; ifc.mem_ack = 1'($urandom);
            @(negedge clk);
            chk({nm, " accept"}, sample(), READY);
        end
        n = tq.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == n) begin
                ifc.instr_valid = pend_v; ifc.instr = pend_i; ifc.mem_ack = 1'b0;
            end else begin
                ifc.instr_valid = 1'($urandom);
                ifc.instr       = $urandom;
                if (!tr_mem || c < 3) ifc.mem_ack = 1'($urandom);
                else                  ifc.mem_ack = (k >= 0) && (c == 3 + k);
            end
            @(negedge clk);
            s = sample();
            chk($sformatf("%s c%0d", nm, c), s, tq[c-1]);
            if (s.done && lat < 0) lat = c;
            if (s.illegal) saw_ill = 1'b1;
            if (s.mem_err) saw_err = 1'b1;
        end
    endtask

    task automatic run_seq(input vec_t lst[$], input bit use_exp);
        int lat;
        bit ill, err;
        for (int i = 0; i < lst.size(); i++) begin
            pend_v = (i + 1 < lst.size()) && lst[i+1].b2b;
            pend_i = pend_v ? lst[i+1].ins : 32'h0;
            run_txn(lst[i].nm, lst[i].ins, lst[i].k, (i > 0) && lst[i].b2b, lat, ill, err);
            if (use_exp) begin
                chk_int({lst[i].nm, " latency"}, lat, lst[i].lat);
                chk_int({lst[i].nm, " illegal"}, int'(ill), int'(lst[i].ill));
                chk_int({lst[i].nm, " mem_err"}, int'(err), int'(lst[i].err));
            end
        end
        pend_v = 1'b0;
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        rl[$];
        vec_t        v;
        logic [5:0]  fn_tab [5];
        logic [31:0] rnd;
        int          r, lat;
        bit          ill, err;
        outs_t       e;

        READY = '0;
        READY.instr_ready = 1'b1;
        fn_tab = '{6'b100000, 6'b100010, 6'b110010, 6'b100100, 6'b100101};

        tbl.push_back('{"ADD",      32'h1C4550A0,  0, 1'b0,  3, 1'b0, 1'b0});
        tbl.push_back('{"SUB",      32'h1C000022,  0, 1'b1,  3, 1'b0, 1'b0});
        tbl.push_back('{"AND",      32'h1C000024,  0, 1'b0,  3, 1'b0, 1'b0});
        tbl.push_back('{"OR",       32'h1C000025,  0, 1'b1,  3, 1'b0, 1'b0});
        tbl.push_back('{"MUL",      32'h1C000032,  0, 1'b0,  6, 1'b0, 1'b0});
        tbl.push_back('{"LW_k2",    32'h23E01500,  2, 1'b1,  6, 1'b0, 1'b0});
        tbl.push_back('{"LW_k0",    32'h23E01500,  0, 1'b0,  4, 1'b0, 1'b0});
        tbl.push_back('{"LW_k14",   32'h20000004, 14, 1'b0, 18, 1'b0, 1'b0});
        tbl.push_back('{"SW_k1",    32'h27E618FF,  1, 1'b1,  5, 1'b0, 1'b0});
        tbl.push_back('{"SW_k0",    32'h27E618FF,  0, 1'b1,  4, 1'b0, 1'b0});
        tbl.push_back('{"SW_tmo",   32'h27E618FF, -1, 1'b0, -1, 1'b0, 1'b1});
        tbl.push_back('{"BADFN",    32'h1C000000,  0, 1'b1, -1, 1'b1, 1'b0});
        tbl.push_back('{"ILLOPC",   32'hFC000000,  0, 1'b0, -1, 1'b1, 1'b0});
        tbl.push_back('{"OR_b2b",   32'h1C000025,  0, 1'b1,  3, 1'b0, 1'b0});

        ifc.instr = '0; ifc.instr_valid = 1'b0; ifc.mem_ack = 1'b0;

        // Reset state, including instr_ready low until the first edge after release.
        #12;
        chk("reset outputs", sample(), ZERO);
        #10 rst_n = 1'b1;
        #1;
        chk("ready before first edge", sample(), ZERO);
        @(negedge clk);
        chk("ready after first edge", sample(), READY);

        run_seq(tbl, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            r   = int'($urandom_range(0, 7));
            if (r < 5)       v.ins = {6'b000111, rnd[25:6], fn_tab[r]};
            else if (r == 5) v.ins = {6'b001000, rnd[25:0]};
            else if (r == 6) v.ins = {6'b001001, rnd[25:0]};
            else             v.ins = rnd;
            v.nm  = $sformatf("rnd%0d", i);
            v.k   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, MEMT - 1));
            v.b2b = 1'($urandom);
            v.lat = -1; v.ill = 1'b0; v.err = 1'b0;
            rl.push_back(v);
        end
        run_seq(rl, 1'b0);

        // Reset asserted in the middle of the multiply wait.
        @(posedge clk); #1;
        ifc.instr = 32'h1C000032; ifc.instr_valid = 1'b1; ifc.mem_ack = 1'b0;
        @(posedge clk); #1; ifc.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = ZERO; e.alu_op = 3'd2; e.reg_dst = 1'b1;
        chk("mulw before reset", sample(), e);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset clears", sample(), ZERO);
        @(posedge clk); #1;
        chk("held in reset", sample(), ZERO);
        rst_n = 1'b1;
        #2;
        chk("released before edge", sample(), ZERO);
        @(posedge clk); #1;
        chk("ready after release", sample(), READY);

        run_txn("ADD_after_rst", 32'h1C4550A0, 0, 1'b0, lat, ill, err);
        chk_int("ADD_after_rst latency", lat, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
